// File: rtl/mp_pkg.sv
// Shared definitions for the pipelined MIPS core: reset/bubble defaults,
// fetch FSM encoding and instruction field positions.
package mp_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DROP  = 2'd2,
      S_HOLD  = 2'd3
   } fetch_state_e;

   // J-type target: upper nibble of the delay-slot PC, instr_index, word aligned.
   function automatic logic [31:0] jump_target(input logic [31:0] pcp4,
                                               input logic [25:0] idx);
      return {pcp4[31:28], idx, 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register plus a one-entry skid buffer that parks a fetched
// word while decode is stalled.
module if_id_reg
   import mp_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        stall_i,
   input  logic        load_i,
   input  logic        load_skid_i,
   input  logic        skid_wr_i,
   input  logic        skid_clr_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pcp4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pcp4_o,
   output logic        valid_o
);

   logic [31:0] skid_instr_q;
   logic [31:0] skid_pcp4_q;
   logic        skid_valid_q;

   // IF/ID register: flush beats stall, stall beats load.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         instr_o <= NOP_INSTR;
         pcp4_o  <= 32'd0;
         valid_o <= 1'b0;
      end else if (flush_i) begin
         instr_o <= NOP_INSTR;
         valid_o <= 1'b0;
      end else if (stall_i) begin
         instr_o <= instr_o;
      end else if (load_i) begin
         if (load_skid_i) begin
            instr_o <= skid_instr_q;
            pcp4_o  <= skid_pcp4_q;
            valid_o <= skid_valid_q;
         end else begin
            instr_o <= instr_i;
            pcp4_o  <= pcp4_i;
            valid_o <= 1'b1;
         end
      end
   end

   // Skid buffer: a clear (drain or discard) wins over a write.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         skid_instr_q <= NOP_INSTR;
         skid_pcp4_q  <= 32'd0;
         skid_valid_q <= 1'b0;
      end else if (skid_clr_i) begin
         skid_valid_q <= 1'b0;
      end else if (skid_wr_i) begin
         skid_instr_q <= instr_i;
         skid_pcp4_q  <= pcp4_i;
         skid_valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem request/ack handshake, branch/jump redirect,
// and the IF/ID register presented to decode.
//
// state   | meaning
// S_IDLE  | first cycle after reset, no request
// S_FETCH | requesting imem at PCF, loading IF/ID on ack
// S_DROP  | redirect taken mid-request; wait for ack, discard it
// S_HOLD  | fetched word parked in skid while decode stalls
module fetch_stage
   import mp_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        mCLK,
   input  logic        RST,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSel,
   input  logic [31:0] PCBranch,
   input  logic        Jump,
   input  logic [25:0] JumpAddr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   output logic [5:0]  op,
   output logic [5:0]  funct
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  tgt_q, tgt_d;
   logic         outst_q, outst_d;

   logic         ack_fire;
   logic         redirect;
   logic [31:0]  redir_tgt;
   logic [31:0]  pc_plus4;
   logic         ifid_flush;
   logic         ifid_load;
   logic         ifid_from_skid;
   logic         skid_wr;
   logic         skid_clr;

   // StallF may only withhold a request that has not been presented yet.
   assign imem_req  = (state_q == S_DROP) ||
                      ((state_q == S_FETCH) && (outst_q || !StallF));
   assign imem_addr = pc_q;
   assign ack_fire  = imem_req & imem_ack;
   assign redirect  = !StallD & (PCSel | Jump);
   assign redir_tgt = (PCSel ? PCBranch : jump_target(PCPlus4D, JumpAddr)) & 32'hFFFF_FFFC;
   assign pc_plus4  = pc_q + 32'd4;

   assign op    = InstrD[OP_MSB:OP_LSB];
   assign funct = InstrD[FUNCT_MSB:FUNCT_LSB];

   // Next PC, pending target and fetch state; IF/ID and skid control strobes.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      tgt_d          = tgt_q;
      outst_d        = imem_req & ~imem_ack;
      ifid_load      = 1'b0;
      ifid_from_skid = 1'b0;
      skid_wr        = 1'b0;
      skid_clr       = redirect;
      ifid_flush     = redirect | FlushD;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            if (redirect) pc_d = redir_tgt;
         end
         S_FETCH: begin
            if (redirect) begin
               if (imem_req && !imem_ack) begin
                  tgt_d   = redir_tgt;
                  state_d = S_DROP;
               end else begin
                  pc_d = redir_tgt;
               end
            end else if (ack_fire) begin
               pc_d = pc_plus4;
               if (StallD) begin
                  skid_wr = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  ifid_load = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d    = redir_tgt;
               state_d = S_FETCH;
            end else if (!StallD) begin
               ifid_load      = 1'b1;
               ifid_from_skid = 1'b1;
               skid_clr       = 1'b1;
               state_d        = S_FETCH;
            end
         end
         S_DROP: begin
            if (ack_fire) begin
               pc_d    = redirect ? redir_tgt : tgt_q;
               state_d = S_FETCH;
            end else if (redirect) begin
               tgt_d = redir_tgt;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Fetch FSM and PC registers.
   always_ff @(posedge mCLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         tgt_q   <= RESET_PC;
         outst_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         outst_q <= outst_d;
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk_i       (mCLK),
      .rst_i       (RST),
      .flush_i     (ifid_flush),
      .stall_i     (StallD),
      .load_i      (ifid_load),
      .load_skid_i (ifid_from_skid),
      .skid_wr_i   (skid_wr),
      .skid_clr_i  (skid_clr),
      .instr_i     (imem_rdata),
      .pcp4_i      (pc_plus4),
      .instr_o     (InstrD),
      .pcp4_o      (PCPlus4D),
      .valid_o     (ValidD)
   );

endmodule
